// File: rtl/rank_filter_nxn_calc.sv
// rank_filter_nxn_calc
//   Pipelined rank-order filter for a WIN x WIN pixel window. Each window can select
//   median, min (erosion), max (dilation) or a programmed rank. ready_i stalls every stage.
//   Latency is 3 enabled cycles. Throughput is one window per enabled cycle.
// Ports
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   done_i       window_i / rank_sel_i / rank_i valid this cycle
//   window_i     N taps; tap k sits at [k*DATA_WIDTH +: DATA_WIDTH], row-major, k=0 top-left
//   rank_sel_i   00 median, 01 min, 10 max, 11 custom rank_i
//   rank_i       custom rank (0 = smallest); values >= N clamp to N-1
//   ready_i      downstream ready; 0 freezes the pipeline
//   ready_o      mirror of ready_i for the upstream block
//   median_o     selected rank value
//   done_o       median_o valid
module rank_filter_nxn_calc #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WIN        = 5,
  localparam int unsigned N         = WIN * WIN,
  localparam int unsigned RW        = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    done_i,
  input  logic [N*DATA_WIDTH-1:0] window_i,
  input  logic [1:0]              rank_sel_i,
  input  logic [RW-1:0]           rank_i,
  input  logic                    ready_i,
  output logic                    ready_o,
  output logic [DATA_WIDTH-1:0]   median_o,
  output logic                    done_o
);

  localparam int unsigned DW = DATA_WIDTH;

  logic en;
  assign en      = ready_i;
  assign ready_o = ready_i;

  // Stage 1: capture taps, valid and effective rank
  logic [N*DW-1:0] s1_win_q;
  logic [RW-1:0]   s1_rank_q;
  logic            s1_vld_q;
  logic [RW-1:0]   rank_d;

  always_comb begin
    rank_d = '0;
    case (rank_sel_i)
      2'b00:   rank_d = RW'((N - 1) / 2);
      2'b01:   rank_d = '0;
      2'b10:   rank_d = RW'(N - 1);
      default: rank_d = (rank_i >= RW'(N)) ? RW'(N - 1) : rank_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_win_q  <= '0;
      s1_rank_q <= '0;
      s1_vld_q  <= 1'b0;
    end else if (en) begin
      s1_win_q  <= window_i;
      s1_rank_q <= rank_d;
      s1_vld_q  <= done_i;
    end
  end

  // Stage 2: rank of every tap. Equal values are ordered by tap index, so the counts
  // always form a permutation of 0..N-1 and stage 3 sees exactly one match.
  logic [N*RW-1:0] cnt_d;
  logic [N*RW-1:0] s2_cnt_q;
  logic [N*DW-1:0] s2_win_q;
  logic [RW-1:0]   s2_rank_q;
  logic            s2_vld_q;

  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if ((s1_win_q[j*DW +: DW] < s1_win_q[i*DW +: DW]) ||
            ((j < i) && (s1_win_q[j*DW +: DW] == s1_win_q[i*DW +: DW]))) begin
          cnt_d[i*RW +: RW] = cnt_d[i*RW +: RW] + RW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_cnt_q  <= '0;
      s2_win_q  <= '0;
      s2_rank_q <= '0;
      s2_vld_q  <= 1'b0;
    end else if (en) begin
      s2_cnt_q  <= cnt_d;
      s2_win_q  <= s1_win_q;
      s2_rank_q <= s1_rank_q;
      s2_vld_q  <= s1_vld_q;
    end
  end

  // Stage 3: one-hot select by OR-reduction (exactly one tap matches)
  logic [DW-1:0] sel_d;

  always_comb begin
    sel_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (s2_cnt_q[i*RW +: RW] == s2_rank_q) begin
        sel_d = sel_d | s2_win_q[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      median_o <= '0;
      done_o   <= 1'b0;
    end else if (en) begin
      median_o <= sel_d;
      done_o   <= s2_vld_q;
    end
  end

endmodule

// File: tb/tb_rank_filter_nxn_calc.sv
module tb_rank_filter_nxn_calc;

  localparam int unsigned DW  = 8;
  localparam int unsigned WIN = 5;
  localparam int unsigned N   = WIN * WIN;
  localparam int unsigned RW  = $clog2(N);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              done_i;
  logic [N*DW-1:0]   window_i;
  logic [1:0]        rank_sel_i;
  logic [RW-1:0]     rank_i;
  logic              ready_i;
  logic              ready_o;
  logic [DW-1:0]     median_o;
  logic              done_o;

  always #5 clk = ~clk;

  rank_filter_nxn_calc #(
    .DATA_WIDTH (DW),
    .WIN        (WIN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .done_i     (done_i),
    .window_i   (window_i),
    .rank_sel_i (rank_sel_i),
    .rank_i     (rank_i),
    .ready_i    (ready_i),
    .ready_o    (ready_o),
    .median_o   (median_o),
    .done_o     (done_o)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic          en_at_edge = 1'b0;
  logic          last_done  = 1'b0;
  logic [DW-1:0] last_med   = '0;
  logic          mon_on     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: sort a copy of the taps and index by the effective rank
  function automatic logic [DW-1:0] model(input logic [N*DW-1:0] w, input logic [1:0] sel,
                                          input logic [RW-1:0] rk);
    logic [DW-1:0] a[N];
    logic [DW-1:0] t;
    int r;
    for (int k = 0; k < N; k++) a[k] = w[k*DW +: DW];
    for (int p = 0; p < N - 1; p++)
      for (int q = 0; q < N - 1 - p; q++)
        if (a[q] > a[q+1]) begin t = a[q]; a[q] = a[q+1]; a[q+1] = t; end
    case (sel)
      2'b00:   r = (N - 1) / 2;
      2'b01:   r = 0;
      2'b10:   r = N - 1;
      default: r = (int'(rk) >= N) ? N - 1 : int'(rk);
    endcase
    return a[r];
  endfunction

  always @(posedge clk) en_at_edge <= ready_i;

  // Output monitor: frozen outputs while stalled, in-order scoreboard otherwise
  always @(negedge clk) begin
    if (mon_on) begin
      if (!en_at_edge) begin
        chk("stall_done", done_o, last_done);
        chk("stall_med", median_o, last_med);
      end else if (done_o) begin
        if (exp_q.size() == 0) chk("unexpected_done", done_o, 1'b0);
        else chk("result", median_o, exp_q.pop_front());
      end
      last_done = done_o;
      last_med  = median_o;
    end
  end

  // Present one window; hold it with ready_i=0 for nstall edges, then let it be captured
  task automatic send(input logic [N*DW-1:0] w, input logic [1:0] sel, input logic [RW-1:0] rk,
                      input logic [DW-1:0] exp, input int nstall);
    @(negedge clk); #1;
    window_i = w; rank_sel_i = sel; rank_i = rk; done_i = 1'b1;
    exp_q.push_back(exp);
    if (nstall > 0) begin
      ready_i = 1'b0;
      repeat (nstall) @(posedge clk);
      @(negedge clk); #1;
    end
    ready_i = 1'b1;
    @(posedge clk);
  endtask

  task automatic drain();
    int k = 0;
    @(negedge clk); #1;
    done_i = 1'b0; ready_i = 1'b1;
    while (exp_q.size() > 0 && k < 20) begin
      @(negedge clk); #2;
      k++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // Single window, checks done_o is low after 2 edges and high after exactly 3
  task automatic latency_check(input logic [N*DW-1:0] w, input logic [DW-1:0] exp);
    send(w, 2'b00, '0, exp, 0);
    @(negedge clk); #1;
    done_i = 1'b0;
    @(posedge clk);
    @(negedge clk); #2;
    chk("lat_e2_done", done_o, 1'b0);
    @(posedge clk);
    @(negedge clk); #2;
    chk("lat_e3_done", done_o, 1'b1);
    chk("lat_popped", exp_q.size(), 0);
  endtask

  logic [N*DW-1:0] perm, mix, flat, w;
  logic [1:0]      s;
  logic [RW-1:0]   r;

  initial begin
    rst_n = 1'b0; done_i = 1'b0; ready_i = 1'b1; window_i = '0; rank_sel_i = '0; rank_i = '0;
    for (int k = 0; k < N; k++) perm[k*DW +: DW] = DW'(((k * 7) % N) + 1);
    for (int k = 0; k < N; k++) begin
      mix[k*DW +: DW] = 8'h7F;
      if (k % 4 == 1 && k < 24) mix[k*DW +: DW] = 8'h00;
      if (k % 4 == 2 && k < 24) mix[k*DW +: DW] = 8'hFF;
    end
    for (int k = 0; k < N; k++) flat[k*DW +: DW] = 8'hA5;

    // Reset state
    #12;
    chk("reset_done", done_o, 1'b0);
    chk("reset_med", median_o, 8'h00);
    chk("ready_pass", ready_o, 1'b1);
    @(negedge clk); #1;
    rst_n = 1'b1;
    mon_on = 1'b1;

    // Median of permutation with exact latency
    latency_check(perm, 8'd13);

    // Other modes and clamp
    send(perm, 2'b01, 5'd0,  8'd1,  0);
    send(perm, 2'b10, 5'd0,  8'd25, 0);
    send(perm, 2'b11, 5'd6,  8'd7,  0);
    send(perm, 2'b11, 5'd30, 8'd25, 0);
    send(mix,  2'b00, 5'd0,  8'h7F, 0);
    for (int m = 0; m < 4; m++) send(flat, 2'(m), 5'd6, 8'hA5, 0);
    drain();

    // Back-to-back windows, mode toggled, stall mid-stream
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < N; k++) w[k*DW +: DW] = DW'($urandom);
      s = 2'(i % 4);
      r = RW'($urandom_range(0, 31));
      send(w, s, r, model(w, s, r), (i == 5) ? 2 : 0);
    end
    drain();

    // Reset with 3 windows in flight
    send(perm, 2'b00, '0, 8'd13, 0);
    send(perm, 2'b01, '0, 8'd1,  0);
    send(perm, 2'b10, '0, 8'd25, 0);
    @(negedge clk); #2;
    done_i = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("rst_async_done", done_o, 1'b0);
    chk("rst_async_med", median_o, 8'h00);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    latency_check(perm, 8'd13);

    // Random windows (half with narrow value range to force ties) and random stalls
    for (int i = 0; i < 200; i++) begin
      for (int k = 0; k < N; k++)
        w[k*DW +: DW] = (i % 2 == 0) ? DW'($urandom) : DW'($urandom_range(0, 3));
      s = 2'($urandom_range(0, 3));
      r = RW'($urandom_range(0, 31));
      send(w, s, r, model(w, s, r), ($urandom_range(0, 7) == 0) ? 1 : 0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
